// File: rtl/frame_former_sub_buffer.sv
`timescale 1ns/1ps
// frame_former_sub_buffer
//   Subordinate storage for the frame former. Beats from the upstream packer
//   are held in a circular buffer of MAX_INTERNAL_SPACE entries and replayed
//   in order on the master stream with first-word-fall-through. The buffer
//   also publishes its occupancy (FFSTail) for the downstream back-pressure
//   gate and the number of complete frames it holds (FrameCount).
//
// Ports
//   ACLK, ARESETN           clock (rising edge), async active-low reset
//   S_AXIS_t*               write stream: tdata/tkeep/tlast stored verbatim
//   M_AXIS_t*               read stream: head beat, read combinationally
//   FFSTail                 beats currently held, 0..MAX_INTERNAL_SPACE
//   FrameCount              stored tlast beats currently held
module frame_former_sub_buffer #(
  parameter int MAX_INTERNAL_SPACE = 64,
  parameter int DATA_WIDTH         = 64
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETN,
  input  logic [DATA_WIDTH-1:0]                S_AXIS_tdata,
  input  logic [DATA_WIDTH/8-1:0]              S_AXIS_tkeep,
  input  logic                                 S_AXIS_tlast,
  input  logic                                 S_AXIS_tvalid,
  output logic                                 S_AXIS_tready,
  output logic [DATA_WIDTH-1:0]                M_AXIS_tdata,
  output logic [DATA_WIDTH/8-1:0]              M_AXIS_tkeep,
  output logic                                 M_AXIS_tlast,
  output logic                                 M_AXIS_tvalid,
  input  logic                                 M_AXIS_tready,
  output logic [$clog2(MAX_INTERNAL_SPACE):0]  FFSTail,
  output logic [$clog2(MAX_INTERNAL_SPACE):0]  FrameCount
);

  localparam int AW = $clog2(MAX_INTERNAL_SPACE);
  localparam int CW = AW + 1;
  localparam int KW = DATA_WIDTH / 8;
  localparam logic [CW-1:0] FULL = CW'(MAX_INTERNAL_SPACE);

  // Storage is deliberately not reset; the head is only meaningful while
  // M_AXIS_tvalid is high.
  logic [DATA_WIDTH-1:0] mem_data [MAX_INTERNAL_SPACE];
  logic [KW-1:0]         mem_keep [MAX_INTERNAL_SPACE];
  logic                  mem_last [MAX_INTERNAL_SPACE];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] frames;

  logic push;
  logic pop;
  logic frame_in;
  logic frame_out;

  // Readiness only looks at the registered count: a full buffer refuses a
  // beat even in a cycle where it is being drained.
  assign S_AXIS_tready = ARESETN & (count != FULL);
  assign M_AXIS_tvalid = (count != '0);

  assign M_AXIS_tdata  = mem_data[rd_ptr];
  assign M_AXIS_tkeep  = mem_keep[rd_ptr];
  assign M_AXIS_tlast  = mem_last[rd_ptr];

  assign FFSTail    = count;
  assign FrameCount = frames;

  assign push      = S_AXIS_tvalid & S_AXIS_tready;
  assign pop       = M_AXIS_tvalid & M_AXIS_tready;
  assign frame_in  = push & S_AXIS_tlast;
  assign frame_out = pop & M_AXIS_tlast;

  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_data[wr_ptr] <= S_AXIS_tdata;
      mem_keep[wr_ptr] <= S_AXIS_tkeep;
      mem_last[wr_ptr] <= S_AXIS_tlast;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      frames <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case ({frame_in, frame_out})
        2'b10:   frames <= frames + 1'b1;
        2'b01:   frames <= frames - 1'b1;
        default: frames <= frames;
      endcase
    end
  end

endmodule
